// File: rtl/sp_divi_pkg.sv
// Shared definitions for the sp_divi restoring divider.
// This package holds the state encoding and the step-counter width helper.
package sp_divi_pkg;

    typedef logic [1:0] sp_state_t;

    localparam sp_state_t SP_DIV_IDLE = 2'd0;
    localparam sp_state_t SP_DIV_BUSY = 2'd1;
    localparam sp_state_t SP_DIV_DONE = 2'd2;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int sp_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/sp_div_step.sv
// One restoring-division step. It shifts the next dividend bit into the partial
// remainder and keeps the trial difference when the subtraction does not borrow.
module sp_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             q_msb_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             qbit_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_in, q_msb_in};
    assign trial   = shifted - {1'b0, b_in};

    always_comb begin
        if (!trial[WIDTH]) begin
            rem_out  = trial[WIDTH-1:0];
            qbit_out = 1'b1;
        end else begin
            rem_out  = shifted[WIDTH-1:0];
            qbit_out = 1'b0;
        end
    end

endmodule

// File: rtl/sp_divi.sv
// Multi-cycle unsigned divider with a start/done handshake.
// It runs one restoring step per clock and returns the quotient and the remainder.
module sp_divi
    import sp_divi_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] c_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int             CNT_W    = sp_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sp_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_nxt;
    logic             qbit;

    sp_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem),
        .q_msb_in (q[WIDTH-1]),
        .b_in     (divisor),
        .rem_out  (rem_nxt),
        .qbit_out (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SP_DIV_IDLE;
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            divisor  <= '0;
            c_out    <= '0;
            r_out    <= '0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                SP_DIV_IDLE: begin
                    // The done pulse is registered, so the divider is back in IDLE while
                    // done_out is high. A start in that cycle is refused.
                    if (start_in && !done_out) begin
                        divisor <= b_in;
                        if (b_in != '0) begin
                            state <= SP_DIV_BUSY;
                            cnt   <= CNT_LOAD;
                            rem   <= '0;
                            q     <= a_in;
                        end else begin
                            state <= SP_DIV_DONE;
                            rem   <= a_in;
                            q     <= '1;
                        end
                    end
                end
                SP_DIV_BUSY: begin
                    rem <= rem_nxt;
                    q   <= {q[WIDTH-2:0], qbit};
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= SP_DIV_DONE;
                    end
                end
                SP_DIV_DONE: begin
                    c_out    <= q;
                    r_out    <= rem;
                    done_out <= 1'b1;
                    state    <= SP_DIV_IDLE;
                end
                default: begin
                    state <= SP_DIV_IDLE;
                end
            endcase
        end
    end

    assign busy_out = (state == SP_DIV_BUSY);

endmodule

// File: tb/tb_sp_divi.sv
// Scoreboard bench for sp_divi. It uses directed 32-bit vectors, reset and start-ignore
// cases, and an 8-bit instance checked against the bench's own divide model.
module tb_sp_divi;

    typedef struct {
        logic [63:0] c;
        logic [63:0] r;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          total;
    int          bad;

    logic        start32;
    logic [31:0] a32, b32, c32, r32;
    logic        busy32, done32;

    logic        start8;
    logic [7:0]  a8, b8, c8, r8;
    logic        busy8, done8;

    exp_t q32[$];
    exp_t q8[$];

    sp_divi #(.WIDTH(32)) u_dut32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start32),
        .a_in     (a32),
        .b_in     (b32),
        .c_out    (c32),
        .r_out    (r32),
        .busy_out (busy32),
        .done_out (done32)
    );

    sp_divi #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start8),
        .a_in     (a8),
        .b_in     (b8),
        .c_out    (c8),
        .r_out    (r8),
        .busy_out (busy8),
        .done_out (done8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done32) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_done32: got done with c=%0h r=%0h want no done", c32, r32);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check("quot32", {32'd0, c32}, e.c);
                check("rem32", {32'd0, r32}, e.r);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_done8: got done with c=%0h r=%0h want no done", c8, r8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("quot8", {56'd0, c8}, e.c);
                check("rem8", {56'd0, r8}, e.r);
            end
        end
    end

    // poke=1: restart attempt mid-BUSY; poke=2: restart attempt in the done_out cycle
    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ec, input logic [31:0] er, input int poke);
        int  start_cyc;
        int  nbusy;
        int  lat;
        bit  seen;
        @(negedge clk);
        start32   = 1'b1;
        a32       = a;
        b32       = b;
        start_cyc = cyc + 1;
        q32.push_back('{c: {32'd0, ec}, r: {32'd0, er}});
        nbusy = 0;
        seen  = 1'b0;
        lat   = -1;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start32 = 1'b0;
                a32     = $urandom;
                b32     = $urandom;
            end
            if (poke == 1 && i == 5) begin
                start32 = 1'b1;
                a32     = 32'd1;
                b32     = 32'd1;
            end
            if (poke == 1 && i == 6) begin
                start32 = 1'b0;
                a32     = 32'd7;
                b32     = 32'd0;
            end
            if (busy32) nbusy++;
            if (done32) begin
                seen = 1'b1;
                lat  = cyc - start_cyc;
            end
        end
        check("latency32", 64'(lat), (b == 0) ? 64'd1 : 64'd33);
        check("busy_cycles32", 64'(nbusy), (b == 0) ? 64'd0 : 64'd32);
        if (poke == 2) begin
            start32 = 1'b1;
            a32     = 32'd9;
            b32     = 32'd3;
            @(negedge clk);
            start32 = 1'b0;
            nbusy   = 0;
            repeat (40) begin
                @(negedge clk);
                if (busy32) nbusy++;
            end
            check("start_on_done_ignored", 64'(nbusy), 64'd0);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int  start_cyc;
        int  lat;
        bit  seen;
        logic [7:0] ec, er;
        if (b == 8'd0) begin
            ec = 8'hFF;
            er = a;
        end else begin
            ec = a / b;
            er = a % b;
        end
        @(negedge clk);
        start8    = 1'b1;
        a8        = a;
        b8        = b;
        start_cyc = cyc + 1;
        q8.push_back('{c: {56'd0, ec}, r: {56'd0, er}});
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start8 = 1'b0;
                a8     = 8'($urandom_range(0, 255));
                b8     = 8'($urandom_range(0, 255));
            end
            if (done8) begin
                seen = 1'b1;
                lat  = cyc - start_cyc;
            end
        end
        check("latency8", 64'(lat), (b == 0) ? 64'd1 : 64'd9);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start32 = 1'b0;
        a32     = '0;
        b32     = '0;
        start8  = 1'b0;
        a8      = '0;
        b8      = '0;
        repeat (3) @(negedge clk);
        check("reset_c", {32'd0, c32}, 64'd0);
        check("reset_r", {32'd0, r32}, 64'd0);
        check("reset_busy", {63'd0, busy32}, 64'd0);
        check("reset_done", {63'd0, done32}, 64'd0);
        rst_n = 1'b1;

        run32(32'd100, 32'd7, 32'd14, 32'd2, 0);
        run32(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
        run32(32'd5, 32'd9, 32'd0, 32'd5, 0);
        run32(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 0);
        run32(32'd1000, 32'd10, 32'd100, 32'd0, 1);
        run32(32'd0, 32'd13, 32'd0, 32'd0, 0);
        run32(32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 0);
        run32(32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD, 32'h0000_BEEF, 2);
        run32(32'd77, 32'd77, 32'd1, 32'd0, 0);

        // Abort a division part-way through. Its result must never appear.
        @(negedge clk);
        start32 = 1'b1;
        a32     = 32'd5000;
        b32     = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_c", {32'd0, c32}, 64'd0);
        check("async_rst_r", {32'd0, r32}, 64'd0);
        check("async_rst_busy", {63'd0, busy32}, 64'd0);
        check("async_rst_done", {63'd0, done32}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run32(32'd45, 32'd6, 32'd7, 32'd3, 0);

        run8(8'd200, 8'd7);
        run8(8'd255, 8'd1);
        run8(8'd3, 8'd250);
        run8(8'd0, 8'd5);
        run8(8'd99, 8'd0);
        for (int k = 0; k < 1000; k++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard32_empty", 64'(q32.size()), 64'd0);
        check("scoreboard8_empty", 64'(q8.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
